// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, default reset vector and the fetch
// redirect FSM state type.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_t;

endpackage : cpu_pkg

// File: rtl/pc_target_calc.sv
// Combinational redirect target: branch/JAL and JALR adders, JALR bit-0 clear,
// jalr > jump > branch priority and a misaligned-target flag.
module pc_target_calc
    import cpu_pkg::*;
(
    input  logic            branch_result,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic            redirect_req,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_rel_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;

    // Both sums wrap modulo 2^XLEN; the carry out is intentionally dropped.
    assign pc_rel_target = ex_pc + imm;
    assign jalr_sum      = rs1_val + imm;
    assign jalr_target   = {jalr_sum[XLEN-1:1], 1'b0};

    assign redirect_req = branch_result | jump | jalr;

    // JAL and taken branches share the PC-relative target, so only jalr
    // needs to win the mux.
    always_comb begin
        target = pc_rel_target;
        if (jalr) begin
            target = jalr_target;
        end
    end

    assign misaligned = redirect_req && (target[1:0] != 2'b00);

endmodule : pc_target_calc

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with EX-stage redirect, stall hold and a sticky
// misaligned-target HALT. PC_REDIRECT_STATS_EN adds a saturating redirect counter.
module pc_redirect_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_result,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            flush,
    output logic            trap,
    output pc_state_t       dbg_state
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [XLEN-1:0] redirect_count
`endif
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            trap_q, trap_d;
    logic            flush_raw;

    logic            redirect_req;
    logic [XLEN-1:0] target;
    logic            misaligned;

    pc_target_calc u_target_calc (
        .branch_result (branch_result),
        .jump          (jump),
        .jalr          (jalr),
        .ex_pc         (ex_pc),
        .imm           (imm),
        .rs1_val       (rs1_val),
        .redirect_req  (redirect_req),
        .target        (target),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        trap_d    = trap_q;
        flush_raw = 1'b0;
        case (state_q)
            RUN: begin
                // A redirect overrides stall: the wrong-path fetch must be killed.
                if (redirect_req) begin
                    flush_raw = 1'b1;
                    if (misaligned) begin
                        state_d = HALT;
                        trap_d  = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            HALT: begin
                flush_raw = 1'b1;
                trap_d    = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // The register is already forced during reset, but flush is combinational
    // and must not leak a kill request while rst is high.
    assign flush     = flush_raw & ~rst;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign trap      = trap_q;
    assign dbg_state = state_q;

`ifdef PC_REDIRECT_STATS_EN
    logic [XLEN-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == RUN && redirect_req && !misaligned && count_q != '1) begin
            count_d = count_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign redirect_count = count_q;
`endif

endmodule : pc_redirect_unit
